// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared FP32 field widths, special codes, flag indices and stage record
package fp32_pkg;

  localparam int WIDTH = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam int EXT_W = EXP_W + 2;

  localparam logic [1:0] SPC_NORM = 2'b00;
  localparam logic [1:0] SPC_ZERO = 2'b01;
  localparam logic [1:0] SPC_INF  = 2'b10;
  localparam logic [1:0] SPC_NAN  = 2'b11;

  localparam logic [WIDTH-1:0] QNAN = 32'h7FC0_0000;
  localparam logic [WIDTH-1:0] PINF = 32'h7F80_0000;

  // Biased exponent at which the result saturates to infinity.
  localparam logic [EXT_W-1:0] EXP_SAT = EXT_W'(2 * BIAS + 1);

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  // Normalized entry: man[26] is the hidden one, [25:3] fraction, [2:0] guard/round/sticky.
  typedef struct packed {
    logic             sign;
    logic [EXT_W-1:0] exp;
    logic [MAN_W+3:0] man;
    logic [1:0]       special;
  } norm_t;

endpackage

// File: rtl/lzc_27.sv
// rtl/lzc_27.sv - leading-zero count over a 27-bit vector; all-zero input yields 27
module lzc_27 (
  input  logic [26:0] vec,
  output logic [4:0]  cnt
);

  always_comb begin
    cnt = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (vec[i]) cnt = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fp32_norm_round.sv
// rtl/fp32_norm_round.sv - two-stage normalize / RNE round-and-pack with FTZ and valid/ready
module fp32_norm_round
  import fp32_pkg::*;
(
  input  logic             clk_n,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W+4:0] in_man,
  input  logic [1:0]       in_special,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags
);

  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  norm_t            s1_q, s1_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;

  logic             s1_adv, s2_adv;
  logic [4:0]       lzc;
  norm_t            norm;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  lzc_27 u_lzc (
    .vec (in_man[26:0]),
    .cnt (lzc)
  );

  // Stage 1: a carry shifts right once (folding the lost bit into sticky), otherwise shift the leading one to bit 26.
  always_comb begin
    norm.sign    = in_sign;
    norm.special = in_special;
    if (in_man[27]) begin
      norm.man = {in_man[27:2], in_man[1] | in_man[0]};
      norm.exp = {2'b00, in_exp} + 10'd1;
    end else begin
      norm.man = in_man[26:0] << lzc;
      norm.exp = {2'b00, in_exp} - {5'd0, lzc};
    end

    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s1_d       = (s1_adv & in_valid) ? norm : s1_q;
  end

  logic             g_bit, r_bit, s_bit, rnd_up;
  logic [MAN_W:0]   frac_sum;
  logic [EXT_W-1:0] exp_f;

  // Stage 2: round to nearest even, then resolve specials, flush-to-zero and overflow.
  always_comb begin
    g_bit    = s1_q.man[2];
    r_bit    = s1_q.man[1];
    s_bit    = s1_q.man[0];
    rnd_up   = g_bit & (r_bit | s_bit | s1_q.man[3]);
    frac_sum = {1'b0, s1_q.man[25:3]} + {{MAN_W{1'b0}}, rnd_up};
    exp_f    = s1_q.exp + {{(EXT_W-1){1'b0}}, frac_sum[MAN_W]};

    res_d   = '0;
    flags_d = '0;
    case (s1_q.special)
      SPC_NAN: begin
        res_d            = QNAN;
        flags_d[FLG_INV] = 1'b1;
      end
      SPC_INF:  res_d = PINF | {s1_q.sign, {(WIDTH-1){1'b0}}};
      SPC_ZERO: res_d = {s1_q.sign, {(WIDTH-1){1'b0}}};
      default: begin
        if (s1_q.man == '0) begin
          res_d = {s1_q.sign, {(WIDTH-1){1'b0}}};
        end else if ($signed(s1_q.exp) <= $signed(10'd0)) begin
          res_d            = {s1_q.sign, {(WIDTH-1){1'b0}}};
          flags_d[FLG_UNF] = 1'b1;
          flags_d[FLG_INX] = 1'b1;
        end else if ($signed(exp_f) >= $signed(EXP_SAT)) begin
          res_d            = PINF | {s1_q.sign, {(WIDTH-1){1'b0}}};
          flags_d[FLG_OVF] = 1'b1;
          flags_d[FLG_INX] = 1'b1;
        end else begin
          res_d            = {s1_q.sign, exp_f[EXP_W-1:0], frac_sum[MAN_W-1:0]};
          flags_d[FLG_INX] = g_bit | r_bit | s_bit;
        end
      end
    endcase

    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    if (!(s2_adv & s1_valid_q)) begin
      res_d   = res_q;
      flags_d = flags_q;
    end
  end

  always_ff @(negedge clk_n or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      res_q      <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = res_q;
  assign out_flags  = flags_q;

endmodule

// File: doc/fp32_norm_round.md
Name: fp32_norm_round

Overview:
Pipelined normalize-and-round stage directly downstream of the FP32 adder's shift/add stage. It takes the unnormalized signed-magnitude sum (exponent plus raw mantissa with carry and guard/round/sticky) and produces a packed IEEE-754 single-precision result with exception flags. It uses round-to-nearest-even (RNE) and flush-to-zero (FTZ; no subnormals). It adds a valid/ready handshake so the approximation engine can apply backpressure.

Parameters:
WIDTH, 32, packed result width
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width
BIAS, 127, exponent bias

Ports:
clk_n  input  1  clock; all registers update on its falling edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream sum valid
in_ready  output  1  stage can accept input this cycle
in_sign  input  1  result sign from adder
in_exp  input  EXP_W  biased exponent of larger operand
in_man  input  MAN_W+5  raw magnitude: [27] carry, [26] integer, [25:3] fraction, [2] guard, [1] round, [0] sticky
in_special  input  2  00 normal, 01 zero, 10 inf, 11 NaN
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_result  output  WIDTH  packed FP32
out_flags  output  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Clock and reset: one clock, clk_n. Reset rst_n is asynchronous, active-low. While reset is asserted: s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_flags=0. in_ready=1 from the first edge after reset release.
- Input value: in_man * 2^(in_exp - BIAS - 26).
- Stage S1 (normalize):
  - in_man[27]=1: shift right 1, OR the shifted-out bit into sticky, exp+1.
  - Otherwise: lzc = leading zeros counted from bit 26. Shift left by lzc, exp - lzc.
  - Exponent arithmetic uses a signed EXP_W+2 bit intermediate; no wrap-around.
- Stage S2 (round/pack):
  - Round up when G & (R | S | lsb).
  - Rounding carry out of the fraction increments exp and sets the fraction to 0.
  - inexact = G | R | S (post-normalize).
- Boundary cases:
  - in_man==0 with in_special=00: result = {in_sign, 0...}, no flags.
  - Normalized exp <= 0: ±0; underflow=1, inexact=1.
  - Final exp >= 255: ±inf (0x7F800000 | sign); overflow=1, inexact=1.
  - in_special=01: ±0. in_special=10: ±inf, no flags. in_special=11: 0x7FC00000, invalid=1. in_man is ignored for all specials.
- Handshake:
  - Latency is 2 cycles from an accepted input (in_valid & in_ready) to out_valid. Throughput is 1 per cycle.
  - s2 advances when ~out_valid | out_ready. s1 advances when ~s2_valid | s2 advances.
  - in_ready = ~s1_valid | s1 advancing (combinational).
  - While out_valid & ~out_ready, out_result and out_flags stay stable. Buffering is 2 entries; there is no loss and no reordering.
- Simultaneous events: accept and emit in the same cycle is legal.
- Reset mid-operation discards all in-flight entries; no output is produced for them.

Decomposition:
- Shared package fp32_pkg holds:
  - EXP_W, MAN_W, BIAS
  - special-code constants (SPC_NORM/ZERO/INF/NAN)
  - QNAN = 32'h7FC00000, PINF = 32'h7F800000
  - flag bit indices
- One sub-module: lzc_27, a combinational leading-zero counter over bits [26:0] returning a 5-bit count.
- Target size: 150–250 lines of RTL.

Test Plan:
1. 1.0+1.0: exp=127, man=0x8000000 -> out_result 0x40000000, flags 0, out_valid 2 cycles after accept.
2. Cancellation: exp=127, man=0x0000008 -> 0x34000000 (2^-23), flags 0. man=0 -> 0x00000000.
3. RNE ties: exp=127, man=0x4000004 -> 0x3F800000 inexact=1. man=0x400000C -> 0x3F800002 inexact=1. man=0x4000005 -> 0x3F800001.
4. Overflow/underflow: exp=254, man=0xFFFFFFF -> 0x7F800000 flags 0b0101. exp=3, man=0x0000008 -> 0x00000000 flags 0b0011.
5. Backpressure: stream 4 inputs back-to-back, hold out_ready=0 for 4 cycles -> in_ready drops once 2 entries are held, out_result stable, all 4 results emerge in order after out_ready=1.
6. Specials/reset: in_special=11 -> 0x7FC00000 flags 0b1000. in_special=10 with sign=1 -> 0xFF800000. Assert rst_n low with 2 entries in flight -> out_valid=0 immediately, nothing emitted after release.
